// File: rtl/set_compare_sequencer.sv
// Shares one 32-bit subtractor between two requesters for slt/seq/sne/sgt/sle/sge.
// Round-robin accept, operand latch, subtract, then a valid/ready response.
module set_compare_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [31:0] sub_a,
  output logic [31:0] sub_b,
  output logic        sub_en,
  input  logic [31:0] sub_diff,
  input  logic        sub_zf,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t     state;
  logic       ptr;     // 1 = requester 1 wins a tie
  logic       id_q;
  logic [2:0] op_q;
  logic       grant0;
  logic       grant1;
  logic       set_bit;
  logic       sign;
  logic       unused_diff;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. Requesters may hold valid without ready; the response side
  // keeps resp_valid/resp_id/resp_data stable until resp_ready is seen.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !rst) begin
      grant0 = req0_valid && (!req1_valid || !ptr);
      grant1 = req1_valid && (!req0_valid ||  ptr);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Sign-only comparison, no overflow correction, matching the existing set units.
  assign sign        = sub_diff[31];
  assign unused_diff = ^sub_diff[30:0];

  always_comb begin
    set_bit = 1'b0;
    case (op_q)
      3'd0: set_bit = sign;
      3'd1: set_bit = sub_zf;
      3'd2: set_bit = !sub_zf;
      3'd3: set_bit = !sub_zf && !sign;
      3'd4: set_bit = sub_zf || sign;
      3'd5: set_bit = !sign;
      default: set_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      id_q       <= 1'b0;
      op_q       <= 3'd0;
      sub_a      <= 32'd0;
      sub_b      <= 32'd0;
      sub_en     <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            sub_a  <= grant1 ? req1_a  : req0_a;
            sub_b  <= grant1 ? req1_b  : req0_b;
            op_q   <= grant1 ? req1_op : req0_op;
            id_q   <= grant1;
            ptr    <= grant0;
            sub_en <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          resp_data  <= {31'd0, set_bit};
          resp_id    <= id_q;
          resp_valid <= 1'b1;
          sub_en     <= 1'b0;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          sub_en     <= 1'b0;
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_set_compare_sequencer.sv
// Bench for set_compare_sequencer: behavioural subtractor, scoreboard of
// {id, data} responses, directed and random set ops.
module tb_set_compare_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] sub_a, sub_b, sub_diff;
  logic        sub_en, sub_zf;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_data;

  logic [32:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  int ops_tab[7]   = '{0, 1, 2, 3, 4, 5, 7};
  int exp_equal[7] = '{0, 1, 0, 0, 1, 1, 0};
  int exp_great[7] = '{0, 0, 1, 1, 0, 1, 0};

  set_compare_sequencer dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .sub_a(sub_a), .sub_b(sub_b), .sub_en(sub_en),
    .sub_diff(sub_diff), .sub_zf(sub_zf),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data)
  );

  // Shared subtractor model
  assign sub_diff = sub_a - sub_b;
  assign sub_zf   = (sub_diff == 32'd0);

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    logic s, z;
    d = a - b;
    s = d[31];
    z = (a == b);
    case (op)
      3'd0: return {31'd0, s};
      3'd1: return {31'd0, z};
      3'd2: return {31'd0, !z};
      3'd3: return {31'd0, !z && !s};
      3'd4: return {31'd0, z || s};
      3'd5: return {31'd0, !s};
      default: return 32'd0;
    endcase
  endfunction

  // Scoreboard and ready exclusivity monitor
  always @(negedge clk) begin
    if (req0_ready && req1_ready) check("ready_excl", 32'd1, 32'd0);
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("resp_id", {31'd0, resp_id}, {31'd0, e[32]});
        check("resp_data", resp_data, e[31:0]);
      end
    end
  end

  task automatic send(input logic id, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
    bit done;
    done = 0;
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        exp_q.push_back({id, exp});
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    check("drain", exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int grants[4];
    int g;
    logic [31:0] held_data;
    logic        held_id;
    bit          seen;

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 3'd0; req1_op = 3'd0;
    req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd0; req1_b = 32'd0;
    resp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_ready0", {31'd0, req0_ready}, 32'd0);
    check("rst_ready1", {31'd0, req1_ready}, 32'd0);
    check("rst_sub_a", sub_a, 32'd0);
    check("rst_sub_b", sub_b, 32'd0);
    check("rst_sub_en", {31'd0, sub_en}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_id", {31'd0, resp_id}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single slt with operand change after accept
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'd3; req0_b = 32'd5;
    @(negedge clk);
    check("slt_ready", {31'd0, req0_ready}, 32'd1);
    exp_q.push_back({1'b0, 32'd1});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req0_a = 32'hffff_ffff;
    @(negedge clk);
    check("slt_sub_en", {31'd0, sub_en}, 32'd1);
    check("slt_sub_a", sub_a, 32'd3);
    check("slt_sub_b", sub_b, 32'd5);
    check("slt_resp_early", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("slt_resp_valid", {31'd0, resp_valid}, 32'd1);
    check("slt_sub_en_off", {31'd0, sub_en}, 32'd0);
    @(posedge clk); #1;
    wait_drain();

    // All ops, equal and greater operands
    for (int i = 0; i < 7; i++)
      send(i[0], ops_tab[i][2:0], 32'd7, 32'd7, exp_equal[i]);
    for (int i = 0; i < 7; i++)
      send(1'b0, ops_tab[i][2:0], 32'd9, 32'd2, exp_great[i]);
    wait_drain();

    // Random ops
    for (int i = 0; i < 16; i++) begin
      logic        id;
      logic [2:0]  op;
      logic [31:0] a, b;
      id = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      send(id, op, a, b, model(op, a, b));
    end
    wait_drain();

    // Round-robin with both requesters held valid
    do_reset();
    req0_valid = 1'b1; req0_op = 3'd2; req0_a = 32'd1; req0_b = 32'd2;
    req1_valid = 1'b1; req1_op = 3'd0; req1_a = 32'd5; req1_b = 32'd1;
    g = 0;
    for (int n = 0; n < 60 && g < 4; n++) begin
      @(negedge clk);
      if (req0_ready) begin
        exp_q.push_back({1'b0, 32'd1}); grants[g] = 0; g++;
      end else if (req1_ready) begin
        exp_q.push_back({1'b1, 32'd0}); grants[g] = 1; g++;
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rr_count", g, 32'd4);
    check("rr_grant0", grants[0], 32'd0);
    check("rr_grant1", grants[1], 32'd1);
    check("rr_grant2", grants[2], 32'd0);
    check("rr_grant3", grants[3], 32'd1);
    wait_drain();

    // Backpressure
    resp_ready = 1'b0;
    send(1'b0, 3'd0, 32'd1, 32'd2, 32'd1);
    req1_valid = 1'b1; req1_op = 3'd3; req1_a = 32'd10; req1_b = 32'd3;
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
      else begin @(posedge clk); #1; end
    end
    check("bp_resp_seen", {31'd0, seen}, 32'd1);
    held_data = resp_data;
    held_id   = resp_id;
    check("bp_held_data", held_data, 32'd1);
    for (int n = 0; n < 5; n++) begin
      if (n > 0) @(negedge clk);
      check("bp_data", resp_data, held_data);
      check("bp_id", {31'd0, resp_id}, {31'd0, held_id});
      check("bp_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_ready1", {31'd0, req1_ready}, 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_ready1_hs", {31'd0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_ready1_after", {31'd0, req1_ready}, 32'd1);
    if (req1_ready) exp_q.push_back({1'b1, 32'd1});
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_drain();

    // Reset during ISSUE
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'd3; req0_b = 32'd5;
    @(negedge clk);
    check("mid_ready0", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    check("mid_issue", {31'd0, sub_en}, 32'd1);
    rst = 1'b1;
    req0_valid = 1'b1; req0_op = 3'd5; req0_a = 32'd4; req0_b = 32'd8;
    req1_valid = 1'b1; req1_op = 3'd1; req1_a = 32'd6; req1_b = 32'd6;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("mid_sub_en", {31'd0, sub_en}, 32'd0);
    check("mid_sub_a", sub_a, 32'd0);
    check("mid_sub_b", sub_b, 32'd0);
    check("mid_resp_data", resp_data, 32'd0);
    check("mid_rst_ready0", {31'd0, req0_ready}, 32'd0);
    check("mid_rst_ready1", {31'd0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_ptr_ready0", {31'd0, req0_ready}, 32'd1);
    check("mid_ptr_ready1", {31'd0, req1_ready}, 32'd0);
    if (req0_ready) exp_q.push_back({1'b0, 32'd0});
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_drain();

    repeat (4) @(posedge clk);
    check("final_queue", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/set_compare_sequencer.md
# set_compare_sequencer

Sequences the shared 32-bit subtractor and the set-condition logic (slt/seq/sne/sgt/sle/sge) for two independent requesters. A winning request is chosen by round-robin arbitration, its operands are latched and driven into the subtractor, and the difference and zero flag are sampled. The 32-bit set result for the requested op is then returned on a valid/ready response port. The block sits between the issue logic and the adder/subtractor datapath, so the set units no longer need a dedicated subtractor per consumer.

## Interface
- No parameters. The data width is fixed at 32.
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `req0_valid`  in  1  requester 0 has a request
- `req0_ready`  out  1  requester 0 request accepted this cycle
- `req0_op`  in  3  set op for requester 0
- `req0_a`  in  32  operand a for requester 0
- `req0_b`  in  32  operand b for requester 0
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`  same as the requester 0 ports, for requester 1
- `sub_a`  out  32  registered minuend to the shared subtractor
- `sub_b`  out  32  registered subtrahend to the shared subtractor
- `sub_en`  out  1  subtractor in use; subtract mode asserted
- `sub_diff`  in  32  combinational a−b from the subtractor
- `sub_zf`  in  1  zero flag of `sub_diff`
- `resp_valid`  out  1  response available
- `resp_ready`  in  1  consumer accepts the response
- `resp_id`  out  1  requester the response belongs to
- `resp_data`  out  32  set result; bits [31:1] are always 0

## Operation
- **Op encoding:** 0 = slt, 1 = seq, 2 = sne, 3 = sgt, 4 = sle, 5 = sge, 6 and 7 = reserved.
- **Result, with s = `sub_diff[31]` and z = `sub_zf` (bit 0 of `resp_data`):**
  - slt = s
  - seq = z
  - sne = !z
  - sgt = !z & !s
  - sle = z | s
  - sge = !s
  - reserved = 0. A reserved op still produces a normal response.
- The result is based on the sign of the difference only, with no overflow correction. This matches the existing set units.
- **FSM states:** IDLE, ISSUE, RESP.
  - **IDLE:** arbitrate. If any `reqN_valid` is high, raise `ready` for the winner only. At the clock edge, latch op, a, b and id into `sub_a`/`sub_b`/op/id registers, then go to ISSUE. If no request is valid, stay in IDLE.
  - **ISSUE:** `sub_en` = 1. At the edge, compute the result from `sub_diff`/`sub_zf`, register it into `resp_data`, set `resp_valid` = 1, then go to RESP.
  - **RESP:** hold `resp_valid`, `resp_data` and `resp_id` stable until `resp_valid & resp_ready` at an edge. Then clear `resp_valid` and go to IDLE.
- **Arbitration:** round-robin with a 1-bit priority pointer.
  - The pointer favors the requester not most recently granted.
  - On reset, the pointer favors requester 0.
  - When exactly one requester is valid, it wins regardless of the pointer.
  - The pointer updates only on a grant.
- **Ready rules:**
  - `req0_ready` and `req1_ready` are never both 1.
  - Neither is 1 outside IDLE.
  - Neither is 1 during reset.
- Requester operands are sampled only at the accept edge. Later changes on the request ports do not affect an in-flight operation.

## Timing
- **Reset values:**
  - state = IDLE, pointer = req0
  - `req0_ready` = `req1_ready` = 0
  - `sub_a` = `sub_b` = 0, `sub_en` = 0
  - `resp_valid` = 0, `resp_id` = 0, `resp_data` = 0
- **Ready timing:** `reqN_ready` is a combinational function of state, pointer and `reqN_valid`. It is valid in the same cycle as `valid`.
- **Latency:** for an accept at edge T, `sub_a`/`sub_b` are valid in cycle T..T+1 and `resp_valid` rises after edge T+1. That is 2 cycles from accept to response.
- **Minimum cycles per operation:** 3 (IDLE, ISSUE, RESP with `resp_ready` already high). The next accept happens in the IDLE cycle after the response handshake.
- **Backpressure:** `resp_ready` held low keeps the FSM in RESP indefinitely. Both `ready` outputs stay 0 during this time.
- **Subtractor operands:** `sub_a`/`sub_b` hold their last values outside ISSUE. `sub_en` = 0 outside ISSUE.
- **Reset mid-operation:** `rst` high at any edge returns the block to the reset values. An in-flight request is dropped without a response, and the requester must reissue it.

## Test plan
- **Single slt:** after reset, req0 sends op=0, a=3, b=5. Expect `req0_ready` = 1 in the same cycle, `sub_en` = 1 one cycle later, and `resp_valid` after 2 edges with `resp_data` = 1 and `resp_id` = 0.
- **All ops:** run ops 0–5 plus op 7 with a = b = 7. Expected `resp_data` in order: 0, 1, 0, 0, 1, 1, 0. Repeat with a=9, b=2 and expect 0, 0, 1, 1, 0, 1, 0.
- **Round-robin:** hold both requesters valid continuously for 4 operations. Expect grants in the order 0, 1, 0, 1, `resp_id` matching each grant, and never both `ready` high at once.
- **Backpressure:** hold `resp_ready` = 0 for 5 cycles while req1 is valid. Expect `resp_data`/`resp_id` stable, `req1_ready` = 0 throughout, and req1 accepted in the cycle after the handshake.
- **Reset mid-operation:** assert `rst` during ISSUE. Expect no response, all outputs at reset values, and the pointer back to req0, so that with both requesters valid, req0 is granted first.
- **Operand isolation:** change `req0_a` from 3 to −1 one cycle after accept. Expect a result computed from the original operands, so slt with b=5 still gives 1.
